// File: rtl/handshaking_rr_arbiter.sv
// Round-robin arbiter that shares one valid/ready slave among N_REQ requesters.
// The winning word is registered and held until the slave accepts it, then the owner gets a one-cycle req_ready.
module handshaking_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_next;
  logic [ID_WIDTH-1:0]   grant_id_next;
  logic [ID_WIDTH-1:0]   winner, cand;
  logic                  found;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  valid_next;
  logic [N_REQ-1:0]      req_ready_next;
  logic [DATA_WIDTH-1:0] req_words [N_REQ];

  genvar i;
  generate
    for (i = 0; i < N_REQ; i++) begin : g_unpack
      assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search starts just past the last winner; index arithmetic wraps because N_REQ == 2**ID_WIDTH.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_grant + ID_WIDTH'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_id_next   = grant_id;
    data_next       = data_out;
    valid_next      = valid_out;
    req_ready_next  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          data_next       = req_words[winner];
          valid_next      = 1'b1;
          grant_id_next   = winner;
          last_grant_next = winner;
          state_next      = SEND;
        end
      end
      SEND: begin
        if (valid_out && ready_in) begin
          valid_next     = 1'b0;
          req_ready_next = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(N_REQ - 1);
      grant_id   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      req_ready  <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_id_next;
      data_out   <= data_next;
      valid_out  <= valid_next;
      req_ready  <= req_ready_next;
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_handshaking_rr_arbiter.sv
// Directed bench for handshaking_rr_arbiter: stimulus pushes expected words into a scoreboard,
// a negedge monitor pops them at each accepted transfer and checks the following req_ready pulse.
module tb_handshaking_rr_arbiter;

  localparam int N_REQ      = 4;
  localparam int ID_WIDTH   = 2;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]       data_out;
  logic                        valid_out;
  logic                        ready_in;
  logic [ID_WIDTH-1:0]         grant_id;
  logic                        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic mon_en = 1'b0;
  logic ack_pending = 1'b0;
  logic [N_REQ-1:0] ack_exp = '0;

  handshaking_rr_arbiter #(
    .N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic ready);
    req_valid = valid;
    ready_in  = ready;
  endtask

  task automatic setData(input int idx, input logic [DATA_WIDTH-1:0] val);
    req_data[idx*DATA_WIDTH +: DATA_WIDTH] = val;
  endtask

  task automatic pushExp(input int id, input logic [DATA_WIDTH-1:0] val);
    exp_t e;
    e.id   = ID_WIDTH'(id);
    e.data = val;
    sb_q.push_back(e);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_valid"}, 32'(valid_out), 32'd0);
    checkOutput({name, "_ready"}, 32'(req_ready), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: a transfer is accepted at the next edge when valid_out and ready_in are both high here.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_pending) begin
        checkOutput("mon_ack", 32'(req_ready), 32'(ack_exp));
        ack_pending = 1'b0;
      end else begin
        checkOutput("mon_no_ack", 32'(req_ready), 32'd0);
      end
      if (valid_out && ready_in && !rst) begin
        if (sb_q.size() == 0) begin
          checkOutput("mon_sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("mon_grant", 32'(grant_id), 32'(e.id));
          checkOutput("mon_data", 32'(data_out), 32'(e.data));
          ack_exp     = {{(N_REQ-1){1'b0}}, 1'b1} << e.id;
          ack_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ID_WIDTH-1:0]   cont_ids  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [DATA_WIDTH-1:0] cont_data [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h11};

    rst = 1'b1;
    req_data = '0;
    applyStimulus(4'b0000, 1'b0);
    step(2);
    rst = 1'b0;
    checkIdle("reset");
    checkOutput("reset_data", 32'(data_out), 32'h0);
    checkOutput("reset_grant", 32'(grant_id), 32'd0);
    mon_en = 1'b1;

    // Single requester
    setData(2, 8'hD4);
    pushExp(2, 8'hD4);
    applyStimulus(4'b0100, 1'b1);
    step(1);
    checkOutput("single_valid", 32'(valid_out), 32'd1);
    checkOutput("single_data", 32'(data_out), 32'hD4);
    checkOutput("single_grant", 32'(grant_id), 32'd2);
    checkOutput("single_busy", 32'(busy), 32'd1);
    step(1);
    checkOutput("single_ack", 32'(req_ready), 32'b0100);
    checkOutput("single_valid_low", 32'(valid_out), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkIdle("single_after");

    // Slave stall
    setData(1, 8'h4D);
    pushExp(1, 8'h4D);
    applyStimulus(4'b0010, 1'b0);
    step(1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_valid", 32'(valid_out), 32'd1);
      checkOutput("stall_data", 32'(data_out), 32'h4D);
      checkOutput("stall_grant", 32'(grant_id), 32'd1);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      if (c < 4) step(1);
    end
    ready_in = 1'b1;
    step(1);
    checkOutput("stall_ack", 32'(req_ready), 32'b0010);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkIdle("stall_after");

    // Full contention after a fresh reset so requester 0 leads
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkIdle("reset2");
    setData(0, 8'h00); setData(1, 8'h11); setData(2, 8'h22); setData(3, 8'h33);
    for (int k = 0; k < 6; k++) pushExp(int'(cont_ids[k]), cont_data[k]);
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1);
      checkOutput("cont_grant", 32'(grant_id), 32'(cont_ids[k]));
      checkOutput("cont_data", 32'(data_out), 32'(cont_data[k]));
      step(1);
      checkOutput("cont_ack", 32'(req_ready), 32'(4'b0001 << cont_ids[k]));
    end
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkIdle("cont_after");

    // Wrap-around priority (last winner is 1 here)
    setData(3, 8'hA3);
    setData(0, 8'hA0);
    pushExp(3, 8'hA3);
    applyStimulus(4'b1000, 1'b1);
    step(1);
    checkOutput("wrap_grant3", 32'(grant_id), 32'd3);
    step(1);
    checkOutput("wrap_ack3", 32'(req_ready), 32'b1000);
    pushExp(0, 8'hA0);
    applyStimulus(4'b1001, 1'b1);
    step(1);
    checkOutput("wrap_grant0", 32'(grant_id), 32'd0);
    checkOutput("wrap_data0", 32'(data_out), 32'hA0);
    step(1);
    checkOutput("wrap_ack0", 32'(req_ready), 32'b0001);
    setData(1, 8'hB1);
    pushExp(1, 8'hB1);
    applyStimulus(4'b0010, 1'b1);
    step(1);
    checkOutput("wrap_grant1", 32'(grant_id), 32'd1);
    step(1);
    checkOutput("wrap_ack1", 32'(req_ready), 32'b0010);
    setData(3, 8'hC3);
    pushExp(3, 8'hC3);
    applyStimulus(4'b1010, 1'b1);
    step(1);
    checkOutput("wrap_skip_grant", 32'(grant_id), 32'd3);
    checkOutput("wrap_skip_data", 32'(data_out), 32'hC3);
    step(1);
    checkOutput("wrap_skip_ack", 32'(req_ready), 32'b1000);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkIdle("wrap_after");

    // Reset while a word is held; it is dropped without an acknowledge
    setData(0, 8'hFF);
    applyStimulus(4'b0001, 1'b0);
    step(1);
    checkOutput("mid_valid", 32'(valid_out), 32'd1);
    checkOutput("mid_data", 32'(data_out), 32'hFF);
    checkOutput("mid_grant", 32'(grant_id), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkIdle("mid_reset");
    checkOutput("mid_reset_grant", 32'(grant_id), 32'd0);
    setData(0, 8'hE0); setData(1, 8'hE1); setData(2, 8'hE2); setData(3, 8'hE3);
    pushExp(0, 8'hE0);
    applyStimulus(4'b1111, 1'b0);
    step(1);
    checkOutput("mid_regrant", 32'(grant_id), 32'd0);
    checkOutput("mid_regrant_data", 32'(data_out), 32'hE0);
    applyStimulus(4'b0000, 1'b1);
    step(1);
    checkOutput("mid_ack", 32'(req_ready), 32'b0001);
    step(1);
    checkIdle("mid_after");

    // Idle with spurious ready toggling
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      ready_in = ~ready_in;
      step(1);
      checkIdle("spurious");
    end

    step(2);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshaking_rr_arbiter.md
Name: handshaking_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready handshaking slave among N_REQ upstream requesters.
- Each requester presents 8-bit data with a valid. The arbiter selects one requester and captures its data into an output register. It holds that word on the slave-facing port until the slave accepts it, then acknowledges the requester.
- Sits between the requester datapaths and the single handshaking slave instance.

Parameters:
- N_REQ, 4, number of requesters; must equal 2**ID_WIDTH.
- ID_WIDTH, 2, width of the grant index.
- DATA_WIDTH, 8, width of each data word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester valid; bit i belongs to requester i.
- req_data  input  N_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_REQ  one-hot, one-cycle acknowledge: the word from requester i has been delivered.
- data_out  output  DATA_WIDTH  registered word to the slave.
- valid_out  output  1  data_out is valid.
- ready_in  input  1  slave ready.
- grant_id  output  ID_WIDTH  index of the requester currently owning the slave.
- busy  output  1  high whenever the state is SEND.

Behaviour:
- Reset (rst=1 at a rising edge), next cycle:
  - state=IDLE, valid_out=0, data_out=0, req_ready=0, grant_id=0, busy=0.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - Reset wins over every other event. A word held in SEND is dropped and no req_ready is issued for it.
- States: IDLE, SEND. The FSM has no other states.
- IDLE:
  - If req_valid==0, stay in IDLE; all outputs hold, with req_ready=0.
  - Otherwise, at the edge, pick winner g: the first set bit of req_valid searching from (last_grant+1) mod N_REQ upward, wrapping at N_REQ-1 -> 0.
  - Register: data_out=req_data[g], valid_out=1, grant_id=g, last_grant=g, busy=1. Go to SEND.
- SEND:
  - data_out, valid_out and grant_id are held stable; req_valid and req_data are ignored.
  - At an edge with valid_out=1 and ready_in=1, the transfer completes.
  - Next cycle after completion: valid_out=0, busy=0, req_ready[grant_id]=1 for exactly one cycle, state=IDLE.
  - If ready_in=0, stay in SEND indefinitely; no timeout.
- req_ready: all bits are 0 in every cycle except the single completion pulse.
- Requester obligations:
  - Hold req_valid and req_data stable until its req_ready pulse.
  - The arbiter samples data at grant, so data changes after the grant edge are harmless.
  - req_valid still high in the pulse cycle (i.e. while the arbiter is in IDLE) counts as a new request, eligible in that same cycle.
- Throughput:
  - Minimum 2 cycles per word: grant edge, then an accept edge with ready_in already high.
  - IDLE with pending requests always grants on the next edge, so back-to-back words run at 1 word per 2 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,… Maximum wait for a requester is N_REQ-1 transfers.
- ready_in while valid_out=0 has no effect.
- data_out keeps its last value after completion; it is only meaningful while valid_out=1.

Test Plan:
- Reset, then a single requester: rst high 2 cycles, then req_valid=4'b0100, req_data[2]=8'hD4, ready_in=1.
  - Required: one edge later valid_out=1, data_out=8'hD4, grant_id=2.
  - Next edge completes the transfer; following cycle req_ready=4'b0100 and valid_out=0.
- Slave stall: req_valid[1]=1 with data 8'h4D; ready_in=0 for 5 cycles, then 1.
  - Required: valid_out=1 and data_out=8'h4D stable for all 5 cycles, req_ready=0 throughout.
  - Single req_ready[1] pulse after ready_in rises.
- Full contention: req_valid=4'b1111 held, data 8'h00, 8'h11, 8'h22, 8'h33, ready_in=1.
  - Required grant_id sequence 0,1,2,3,0,1; data_out matches each grant.
  - One req_ready pulse every 2 cycles.
- Wrap-around priority: after requester 3 is granted, req_valid=4'b1001.
  - Required: next grant is 0. With req_valid=4'b1010 following a grant to 1, next grant is 3.
- Reset mid-operation: enter SEND with req_valid[0]=1 and data 8'hFF, ready_in=0; assert rst for 1 cycle.
  - Required: next cycle valid_out=0, busy=0, req_ready=0, grant_id=0.
  - No req_ready pulse for the dropped word; the next arbitration starts from requester 0.
- Idle and spurious ready: req_valid=0, ready_in toggling for 10 cycles.
  - Required: valid_out=0, req_ready=0, busy=0 throughout.
